// File: rtl/sar_compare_search.sv
// Successive-approximation search engine driving a 3-flag magnitude comparator.
// One trial per bit, MSB first, with early exit on an equal flag.
module sar_compare_search #(
  parameter int WIDTH    = 8,
  parameter int CMP_WAIT = 1
) (
  input  logic                       Clock_In,
  input  logic                       Reset_In,
  input  logic                       Start_In,
  input  logic                       A_gt_B_In,
  input  logic                       A_eq_B_In,
  input  logic                       A_lt_B_In,
  output logic                       Compare_Enable_Out,
  output logic [WIDTH-1:0]           Guess_Out,
  output logic [WIDTH-1:0]           Result_Out,
  output logic [$clog2(WIDTH+1)-1:0] Trials_Out,
  output logic                       Busy_Out,
  output logic                       Done_Out,
  output logic                       Found_Out,
  output logic                       Error_Out
);

  localparam int TW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = (CMP_WAIT > 0) ? $clog2(CMP_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TW-1:0]    trials_q, trials_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic             busy_q, done_q, error_q;
  logic [WIDTH-1:0] upd_guess;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    guess_d   = guess_q;
    result_d  = result_q;
    trials_d  = trials_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    upd_guess = guess_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start_In) begin
          state_d               = TRIAL;
          guess_d               = '0;
          guess_d[WIDTH-1]      = 1'b1;
          idx_d                 = IW'(WIDTH - 1);
          cnt_d                 = CW'(CMP_WAIT);
          trials_d              = '0;
          found_d               = 1'b0;
        end
      end
      TRIAL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          trials_d = trials_q + 1'b1;
          // X/Z or multi-hot flags never match a legal pattern and fall to ERROR.
          case ({A_gt_B_In, A_eq_B_In, A_lt_B_In})
            3'b010: begin
              result_d = guess_q;
              found_d  = 1'b1;
              state_d  = DONE;
            end
            3'b100, 3'b001: begin
              if (A_gt_B_In) upd_guess[idx_q] = 1'b0;
              if (idx_q != '0) begin
                upd_guess[idx_q - 1'b1] = 1'b1;
                idx_d                   = idx_q - 1'b1;
                cnt_d                   = CW'(CMP_WAIT);
              end else begin
                result_d = upd_guess;
                state_d  = DONE;
              end
              guess_d = upd_guess;
            end
            default: state_d = ERROR;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      result_q <= '0;
      trials_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      trials_q <= trials_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      busy_q   <= (state_d == TRIAL);
      done_q   <= (state_d == DONE) || (state_d == ERROR);
      error_q  <= (state_d == ERROR);
    end
  end

  assign Compare_Enable_Out = busy_q;
  assign Busy_Out           = busy_q;
  assign Guess_Out          = guess_q;
  assign Result_Out         = result_q;
  assign Trials_Out         = trials_q;
  assign Done_Out           = done_q;
  assign Found_Out          = found_q;
  assign Error_Out          = error_q;

endmodule

// File: tb/tb_sar_compare_search.sv
// Bench for sar_compare_search: behavioural comparators around two instances
// (CMP_WAIT=1 and CMP_WAIT=0) with a queue of expected search outcomes.
module tb_sar_compare_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] t0, t1;
  logic       kill0;

  logic       en0, busy0, done0, found0, err0, gt0, eq0, lt0;
  logic [7:0] g0, r0;
  logic [3:0] tr0;
  logic       en1, busy1, done1, found1, err1, gt1, eq1, lt1;
  logic [7:0] g1, r1;
  logic [3:0] tr1;

  assign {gt0, eq0, lt0} = (en0 && !kill0) ? {g0 > t0, g0 == t0, g0 < t0} : 3'bzzz;
  assign {gt1, eq1, lt1} = en1 ? {g1 > t1, g1 == t1, g1 < t1} : 3'bzzz;

  sar_compare_search #(.WIDTH(8), .CMP_WAIT(1)) dut0 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start0),
    .A_gt_B_In(gt0), .A_eq_B_In(eq0), .A_lt_B_In(lt0),
    .Compare_Enable_Out(en0), .Guess_Out(g0), .Result_Out(r0), .Trials_Out(tr0),
    .Busy_Out(busy0), .Done_Out(done0), .Found_Out(found0), .Error_Out(err0)
  );

  sar_compare_search #(.WIDTH(8), .CMP_WAIT(0)) dut1 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start1),
    .A_gt_B_In(gt1), .A_eq_B_In(eq1), .A_lt_B_In(lt1),
    .Compare_Enable_Out(en1), .Guess_Out(g1), .Result_Out(r1), .Trials_Out(tr1),
    .Busy_Out(busy1), .Done_Out(done1), .Found_Out(found1), .Error_Out(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] result;
    logic       found;
    int         trials;
    logic       error;
    int         lat;
    logic [7:0] gs [8];
  } exp_t;

  exp_t       sb [$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last0  = 8'h00;
  logic [7:0] last1  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference SAR outcome: set each bit MSB first, keep it unless the guess overshoots.
  function automatic exp_t model(input logic [7:0] t, input bit kill, input int cw,
                                 input logic [7:0] last);
    exp_t       e;
    logic [7:0] g;
    g        = 8'h00;
    e.found  = 1'b0;
    e.error  = 1'b0;
    e.trials = 0;
    e.result = 8'h00;
    for (int k = 0; k < 8; k++) e.gs[k] = 8'h00;
    if (kill) begin
      e.error  = 1'b1;
      e.trials = 1;
      e.result = last;
      e.gs[0]  = 8'h80;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        g[i]             = 1'b1;
        e.gs[e.trials]   = g;
        e.trials++;
        if (g == t) begin
          e.found = 1'b1;
          break;
        end
        if (g > t) g[i] = 1'b0;
      end
      e.result = g;
    end
    e.lat = e.trials * (cw + 1);
    return e;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic run(input int which, input logic [7:0] t, input bit kill, input int mid_start);
    exp_t       e;
    int         cw, cyc, n;
    logic [7:0] obs_g [8];
    logic       o_en, o_busy, o_done, o_found, o_err;
    logic [7:0] o_r, o_g;
    logic [3:0] o_tr;
    cw = (which == 0) ? 1 : 0;
    sb.push_back(model(t, kill, cw, (which == 0) ? last0 : last1));
    if (which == 0) begin
      t0    = t;
      kill0 = kill;
    end else begin
      t1 = t;
    end
    for (int k = 0; k < 8; k++) obs_g[k] = 8'h00;
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    check($sformatf("busy_after_start_d%0d", which), (which == 0) ? busy0 : busy1, 1);
    check($sformatf("error_cleared_d%0d", which), (which == 0) ? err0 : err1, 0);
    cyc = 0;
    n   = 0;
    obs_g[n++] = (which == 0) ? g0 : g1;
    while (!((which == 0) ? done0 : done1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mid_start > 0 && cyc == mid_start) set_start(which, 1'b1);
      if (mid_start > 0 && cyc == mid_start + 1) set_start(which, 1'b0);
      if (((which == 0) ? busy0 : busy1) && (cyc % (cw + 1) == 0) && n < 8)
        obs_g[n++] = (which == 0) ? g0 : g1;
    end
    set_start(which, 1'b0);
    if (which == 0) begin
      o_en = en0; o_busy = busy0; o_done = done0; o_found = found0;
      o_err = err0; o_r = r0; o_g = g0; o_tr = tr0;
    end else begin
      o_en = en1; o_busy = busy1; o_done = done1; o_found = found1;
      o_err = err1; o_r = r1; o_g = g1; o_tr = tr1;
    end
    e = sb.pop_front();
    check($sformatf("done_t%0h", t), o_done, 1);
    check($sformatf("latency_t%0h", t), cyc, e.lat);
    check($sformatf("result_t%0h", t), o_r, e.result);
    check($sformatf("found_t%0h", t), o_found, e.found);
    check($sformatf("error_t%0h", t), o_err, e.error);
    check($sformatf("trials_t%0h", t), o_tr, e.trials);
    check($sformatf("cmp_en_low_t%0h", t), o_en, 0);
    check($sformatf("busy_low_t%0h", t), o_busy, 0);
    for (int k = 0; k < e.trials && k < 8; k++)
      check($sformatf("guess%0d_t%0h", k + 1, t), obs_g[k], e.gs[k]);
    if (which == 0) last0 = e.result;
    else last1 = e.result;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en0"}, en0, 0);
    check({tag, "_guess0"}, g0, 0);
    check({tag, "_result0"}, r0, 0);
    check({tag, "_trials0"}, tr0, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_found0"}, found0, 0);
    check({tag, "_error0"}, err0, 0);
    check({tag, "_done1"}, done1, 0);
    check({tag, "_guess1"}, g1, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    t0     = 8'h00;
    t1     = 8'h00;
    kill0  = 1'b0;
    #2;
    check_zero("reset");
    #10 rst = 1'b0;

    run(0, 8'h80, 1'b0, 0);
    run(0, 8'h00, 1'b0, 0);
    run(0, 8'h00, 1'b1, 0);
    run(0, 8'h37, 1'b0, 5);

    t0    = 8'hA5;
    kill0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst   = 1'b0;
    last0 = 8'h00;
    last1 = 8'h00;
    run(0, 8'hA5, 1'b0, 0);

    run(1, 8'hFF, 1'b0, 0);
    run(1, 8'h5A, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
